clkgen_csr_bank: RTL and testbench
==================================

Name: clkgen_csr_bank

Overview:
Parametrised configuration register bank for an N-channel PLL/clock-generator array. It generalises the fixed 4-channel nibble CSR with immediate writes. All writes land in shadow registers, and a commit sequence applies them atomically per channel. During a commit, affected channels are gated off, the new divider and select settings are applied, and the channels are held off for a settle window before re-enabling. It sits between the pad-level CSR write interface and the analog PLL macro inputs: div_fb, div_out, clk_sel and enb.

Parameters:
NCH, 4, number of PLL channels (2..16)
DIV_W, 4, width of each feedback and output divider field
SEL_W, 2, width of each reference-select field (sel 0 = external clk; sel k = k-th other channel)
GATE_CYC, 4, cycles channels are gated before new settings are applied (>=1)
SETTLE_CYC, 16, cycles channels stay gated after apply (>=1)

Ports:
clk  in  1  single clock; all state is on its rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write strobe, one write per cycle
wr_addr  in  $clog2(NCH)+2  {channel, field}; field 0=div_fb, 1=div_out, 2=clk_sel, 3=enb
wr_data  in  DIV_W  write data, LSB-aligned; clk_sel uses [SEL_W-1:0], enb uses [0]
commit  in  1  single-cycle request to apply all dirty channels
rd_en  in  1  read strobe (CSR_READBACK_EN only)
rd_addr  in  $clog2(NCH)+2  read address, same map as wr_addr
rd_data  out  DIV_W  registered shadow readback
div_fb  out  NCH*DIV_W  active feedback dividers; channel i at [i*DIV_W +: DIV_W]
div_out  out  NCH*DIV_W  active output dividers
clk_sel  out  NCH*SEL_W  active reference selects
enb  out  NCH  effective channel enables
busy  out  1  high while a commit sequence is running
err  out  1  sticky flag: an illegal divider write was clamped

Behaviour:
- Reset values:
  - Shadow and active div_fb and div_out = 1.
  - clk_sel = 0.
  - Shadow and active enb = all 1s.
  - dirty = 0, busy = 0, err = 0, rd_data = 0, pending = 0.
  - FSM = IDLE.
- Write handling:
  - A write is accepted every cycle wr_en=1, in any state. It updates shadow only and sets dirty[ch].
  - Channel index >= NCH: write ignored, no dirty bit set.
  - Divider write with data 0: stores 1 and sets err. err is cleared only by rst.
- FSM states: IDLE -> QUIESCE -> APPLY -> SETTLE -> IDLE.
- IDLE:
  - commit=1 with dirty!=0: snapshot mask = dirty; go to QUIESCE next cycle.
  - commit=1 with dirty==0: ignored.
- QUIESCE: lasts GATE_CYC cycles.
- APPLY: lasts 1 cycle.
  - For each channel in mask, copy shadow -> active for all four fields.
  - Clear dirty for mask channels, except a channel written in this same cycle keeps dirty=1; the new value lands in shadow only.
- SETTLE: lasts SETTLE_CYC cycles, then IDLE.
- busy: high from the cycle after commit is sampled through the last SETTLE cycle, i.e. exactly GATE_CYC+1+SETTLE_CYC cycles.
- enb output:
  - enb[i] = active_enb[i] & ~(busy & mask[i]).
  - Unmasked channels are never disturbed.
- Active outputs change only on the APPLY edge. They are glitch-free registered outputs.
- Commit while busy: latched into pending, cleared at the next IDLE entry.
  - On IDLE entry with pending=1 and dirty!=0, a new sequence starts on the next cycle.
  - Multiple commits while busy collapse into one.
- rst mid-sequence: immediate return to reset values. Gated channels come back enabled with div=1 and sel=0.

Optional Feature:
Macro: CSR_READBACK_EN
- Defined:
  - rd_en=1 returns the shadow field at rd_addr on rd_data the next cycle; rd_data holds otherwise.
  - Fields narrower than DIV_W are zero-extended.
  - Out-of-range channel reads return 0.
  - A read and a write to the same address in one cycle return the old value.
- Not defined: rd_data tied to 0; rd_en and rd_addr are unused.

Test Plan:
- Reset release: outputs match reset values (div_fb/div_out all 1, clk_sel 0, enb all 1s), busy=0, err=0; a commit with no prior writes leaves busy=0.
- Write ch2 div_fb=5, div_out=3, then commit at cycle t -> ch2 active outputs unchanged until APPLY at t+1+GATE_CYC, then 5/3; enb[2]=0 for exactly 21 cycles (defaults); busy=1 for 21 cycles; enb[0,1,3] stay 1.
- Write ch1 div_out=0 -> shadow reads 1, err=1 and stays 1 until rst.
- Commit with ch0 dirty, write ch3 clk_sel=2 during SETTLE, commit again during SETTLE -> the second sequence starts the cycle after IDLE entry and gates only ch3; ch3 clk_sel=2 after its APPLY.
- Write ch0 div_fb=7 in the same cycle as APPLY for ch0 (old shadow 4) -> active=4, dirty[0] remains 1; the next commit applies 7.
- Assert rst during QUIESCE with ch1 gated -> next cycle enb=all 1s, busy=0, ch1 div_fb=1; with CSR_READBACK_EN, reading ch1 field 0 returns 1.

Source files
------------

// File: rtl/clkgen_csr_bank.sv
// clkgen_csr_bank: shadowed CSR bank for an NCH-channel PLL/clock-generator array.
// Writes land in shadow registers; a commit gates the dirty channels, applies
// their shadow settings atomically, holds them gated for a settle window and
// then re-enables them. Unaffected channels keep running undisturbed.
// Optional feature macro: CSR_READBACK_EN (registered shadow readback port).
module clkgen_csr_bank #(
    parameter int NCH        = 4,
    parameter int DIV_W      = 4,
    parameter int SEL_W      = 2,
    parameter int GATE_CYC   = 4,
    parameter int SETTLE_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [$clog2(NCH)+1:0] wr_addr,
    input  logic [DIV_W-1:0]       wr_data,
    input  logic                   commit,
    input  logic                   rd_en,
    input  logic [$clog2(NCH)+1:0] rd_addr,
    output logic [DIV_W-1:0]       rd_data,
    output logic [NCH*DIV_W-1:0]   div_fb,
    output logic [NCH*DIV_W-1:0]   div_out,
    output logic [NCH*SEL_W-1:0]   clk_sel,
    output logic [NCH-1:0]         enb,
    output logic                   busy,
    output logic                   err
);

    localparam int CH_W    = $clog2(NCH);
    localparam int CH_W1   = CH_W + 1;
    localparam int CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CH_W:0]    NCH_L       = CH_W1'(NCH);
    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1'b1);
    localparam logic [NCH-1:0]   CH_ZERO     = {NCH{1'b0}};
    localparam logic [NCH-1:0]   CH_ONEHOT0  = NCH'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUIESCE = 2'd1,
        ST_APPLY   = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    state_t               state_r, state_next_s;
    logic [CNT_W-1:0]     cnt_r, cnt_next_s;
    logic [NCH-1:0]       mask_r, mask_next_s;
    logic [NCH-1:0]       dirty_r, dirty_next_s, dirty_set_s;
    logic                 pending_r, pending_next_s;
    logic                 apply_s;
    logic                 busy_r, enb_unused_busy_s;
    logic [NCH-1:0]       enb_r;
    logic                 err_r;

    logic [DIV_W-1:0]     sh_fb_r  [NCH];
    logic [DIV_W-1:0]     sh_out_r [NCH];
    logic [SEL_W-1:0]     sh_sel_r [NCH];
    logic [NCH-1:0]       sh_enb_r;

    logic [NCH*DIV_W-1:0] act_fb_r, act_out_r;
    logic [NCH*SEL_W-1:0] act_sel_r;
    logic [NCH-1:0]       act_enb_r, act_enb_next_s;

    logic [CH_W-1:0]      wr_ch_s;
    logic [1:0]           wr_fld_s;
    logic                 wr_ok_s;
    logic                 wr_zero_s;
    logic [DIV_W-1:0]     wr_div_s;

    // Decode the write address; a zero divider is clamped to 1.
    always_comb begin
        wr_ch_s   = wr_addr[CH_W+1:2];
        wr_fld_s  = wr_addr[1:0];
        wr_ok_s   = wr_en && ({1'b0, wr_ch_s} < NCH_L);
        wr_zero_s = (wr_data == {DIV_W{1'b0}});
        wr_div_s  = wr_zero_s ? DIV_ONE : wr_data;
        if (wr_ok_s) begin
            dirty_set_s = CH_ONEHOT0 << wr_ch_s;
        end else begin
            dirty_set_s = CH_ZERO;
        end
        // A write in the APPLY cycle re-marks its channel after the mask clear.
        dirty_next_s = (apply_s ? (dirty_r & ~mask_r) : dirty_r) | dirty_set_s;
    end

    // Commit sequencer: next state, phase counter, channel mask and pending request.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        mask_next_s    = mask_r;
        pending_next_s = pending_r;
        apply_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pending_next_s = 1'b0;
                if ((commit || pending_r) && (dirty_r != CH_ZERO)) begin
                    state_next_s = ST_QUIESCE;
                    cnt_next_s   = CNT_ZERO;
                    mask_next_s  = dirty_r;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_QUIESCE: begin
                pending_next_s = pending_r | commit;
                if (cnt_r == GATE_LAST) begin
                    state_next_s = ST_APPLY;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_APPLY: begin
                pending_next_s = pending_r | commit;
                apply_s        = 1'b1;
                state_next_s   = ST_SETTLE;
                cnt_next_s     = CNT_ZERO;
            end
            ST_SETTLE: begin
                pending_next_s = pending_r | commit;
                if (cnt_r == SETTLE_LAST) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
        // Active enables only move on the APPLY edge.
        if (apply_s) begin
            act_enb_next_s = (act_enb_r & ~mask_r) | (sh_enb_r & mask_r);
        end else begin
            act_enb_next_s = act_enb_r;
        end
        enb_unused_busy_s = (state_next_s != ST_IDLE);
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            mask_r    <= CH_ZERO;
            pending_r <= 1'b0;
            dirty_r   <= CH_ZERO;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            mask_r    <= mask_next_s;
            pending_r <= pending_next_s;
            dirty_r   <= dirty_next_s;
        end
    end

    // Shadow registers and the sticky clamp flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                sh_fb_r[i]  <= DIV_ONE;
                sh_out_r[i] <= DIV_ONE;
                sh_sel_r[i] <= {SEL_W{1'b0}};
            end
            sh_enb_r <= {NCH{1'b1}};
            err_r    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                case (wr_fld_s)
                    2'd0:    sh_fb_r[wr_ch_s]  <= wr_div_s;
                    2'd1:    sh_out_r[wr_ch_s] <= wr_div_s;
                    2'd2:    sh_sel_r[wr_ch_s] <= wr_data[SEL_W-1:0];
                    2'd3:    sh_enb_r[wr_ch_s] <= wr_data[0];
                    default: sh_enb_r <= sh_enb_r;
                endcase
            end
            err_r <= err_r | (wr_ok_s && !wr_fld_s[1] && wr_zero_s);
        end
    end

    // Active settings: copied from shadow for masked channels on the APPLY edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_fb_r  <= {NCH{DIV_ONE}};
            act_out_r <= {NCH{DIV_ONE}};
            act_sel_r <= {(NCH*SEL_W){1'b0}};
            act_enb_r <= {NCH{1'b1}};
        end else begin
            act_enb_r <= act_enb_next_s;
            if (apply_s) begin
                for (int i = 0; i < NCH; i++) begin
                    if (mask_r[i]) begin
                        act_fb_r[i*DIV_W +: DIV_W]  <= sh_fb_r[i];
                        act_out_r[i*DIV_W +: DIV_W] <= sh_out_r[i];
                        act_sel_r[i*SEL_W +: SEL_W] <= sh_sel_r[i];
                    end
                end
            end
        end
    end

    // Registered busy and gated enables, derived from next-cycle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            enb_r  <= {NCH{1'b1}};
        end else begin
            busy_r <= enb_unused_busy_s;
            enb_r  <= act_enb_next_s & ~(mask_next_s & {NCH{enb_unused_busy_s}});
        end
    end

`ifdef CSR_READBACK_EN
    logic [DIV_W-1:0] rd_data_r, rd_next_s;
    logic [CH_W-1:0]  rd_ch_s;

    // Shadow readback mux; narrow fields are zero-extended, bad channels read 0.
    always_comb begin
        rd_ch_s   = rd_addr[CH_W+1:2];
        rd_next_s = {DIV_W{1'b0}};
        if ({1'b0, rd_ch_s} < NCH_L) begin
            case (rd_addr[1:0])
                2'd0:    rd_next_s = sh_fb_r[rd_ch_s];
                2'd1:    rd_next_s = sh_out_r[rd_ch_s];
                2'd2:    rd_next_s = DIV_W'(sh_sel_r[rd_ch_s]);
                2'd3:    rd_next_s = DIV_W'(sh_enb_r[rd_ch_s]);
                default: rd_next_s = {DIV_W{1'b0}};
            endcase
        end else begin
            rd_next_s = {DIV_W{1'b0}};
        end
    end

    // Readback register: loads on rd_en, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DIV_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_next_s;
        end
    end

    assign rd_data = rd_data_r;
`else
    logic unused_rd_s;
    assign unused_rd_s = ^{rd_en, rd_addr};
    assign rd_data     = {DIV_W{1'b0}};
`endif

    assign div_fb  = act_fb_r;
    assign div_out = act_out_r;
    assign clk_sel = act_sel_r;
    assign enb     = enb_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// File: tb/tb_clkgen_csr_bank.sv
// Directed scoreboard bench for clkgen_csr_bank with default parameters.
// Expectations are queued before each clock edge and checked right after it.
module tb_clkgen_csr_bank;

    localparam int O_FB = 0, O_OUT = 1, O_SEL = 2, O_ENB = 3, O_BUSY = 4, O_ERR = 5, O_RD = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        commit;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [3:0]  rd_data;
    logic [15:0] div_fb;
    logic [15:0] div_out;
    logic [7:0]  clk_sel;
    logic [3:0]  enb;
    logic        busy;
    logic        err;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    clkgen_csr_bank dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .commit  (commit),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .div_fb  (div_fb),
        .div_out (div_out),
        .clk_sel (clk_sel),
        .enb     (enb),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            O_FB:    return {16'd0, div_fb};
            O_OUT:   return {16'd0, div_out};
            O_SEL:   return {24'd0, clk_sel};
            O_ENB:   return {28'd0, enb};
            O_BUSY:  return {31'd0, busy};
            O_ERR:   return {31'd0, err};
            O_RD:    return {28'd0, rd_data};
            default: return 32'hdead_beef;
        endcase
    endfunction

    function automatic logic [3:0] rdx(logic [3:0] v);
`ifdef CSR_READBACK_EN
        return v;
`else
        return 4'd0 & v;
`endif
    endfunction

    task automatic push(string tag, int sel, logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic push_cycle(string pfx, int k, logic b, logic [3:0] en,
                              logic [15:0] fb, logic [15:0] dout, logic [7:0] sl);
        push($sformatf("%s_k%0d_busy", pfx, k), O_BUSY, {31'd0, b});
        push($sformatf("%s_k%0d_enb", pfx, k), O_ENB, {28'd0, en});
        push($sformatf("%s_k%0d_fb", pfx, k), O_FB, {16'd0, fb});
        push($sformatf("%s_k%0d_out", pfx, k), O_OUT, {16'd0, dout});
        push($sformatf("%s_k%0d_sel", pfx, k), O_SEL, {24'd0, sl});
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.sel);
            n_tests++;
            assert (o === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic wr(logic [1:0] ch, logic [1:0] fld, logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = {ch, fld};
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(string tag, logic [1:0] ch, logic [1:0] fld, logic [3:0] v);
        rd_en   = 1'b1;
        rd_addr = {ch, fld};
        push(tag, O_RD, {28'd0, rdx(v)});
        tick();
        rd_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
        commit = 1'b0; rd_en = 1'b0; rd_addr = 4'd0;
        tick();
        tick();

        // Reset release and a commit with nothing dirty.
        push("rst_fb", O_FB, 32'h1111);
        push("rst_out", O_OUT, 32'h1111);
        push("rst_sel", O_SEL, 32'h0);
        push("rst_enb", O_ENB, 32'hf);
        push("rst_busy", O_BUSY, 32'h0);
        push("rst_err", O_ERR, 32'h0);
        push("rst_rd", O_RD, 32'h0);
        rst = 1'b0;
        tick();
        commit = 1'b1;
        push("empty_commit_busy0", O_BUSY, 32'h0);
        tick();
        commit = 1'b0;
        push("empty_commit_busy1", O_BUSY, 32'h0);
        push("empty_commit_enb", O_ENB, 32'hf);
        tick();

        // Channel 2 dividers, then a full commit sequence.
        wr(2'd2, 2'd0, 4'd5);
        wr(2'd2, 2'd1, 4'd3);
        rd("rd_ch2_fb", 2'd2, 2'd0, 4'd5);
        rd("rd_ch2_out", 2'd2, 2'd1, 4'd3);
        commit = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            push_cycle("c2", k, k <= 21, (k <= 21) ? 4'b1011 : 4'hf,
                       (k >= 6) ? 16'h1511 : 16'h1111,
                       (k >= 6) ? 16'h1311 : 16'h1111, 8'h00);
            tick();
            commit = 1'b0;
        end

        // Zero divider write is clamped and flags err.
        wr_en = 1'b1; wr_addr = {2'd1, 2'd1}; wr_data = 4'd0;
        push("clamp_err", O_ERR, 32'h1);
        tick();
        wr_en = 1'b0;
        rd("rd_clamp", 2'd1, 2'd1, 4'd1);
        push("clamp_err_hold", O_ERR, 32'h1);
        push("clamp_out_active", O_OUT, 32'h1311);
        tick();

        // Commit ch0/ch1, write ch3 sel and re-commit during SETTLE.
        wr(2'd0, 2'd0, 4'd4);
        for (int k = 1; k <= 44; k++) begin
            wr_en   = (k == 9);
            wr_addr = {2'd3, 2'd2};
            wr_data = 4'd2;
            commit  = (k == 1) || (k == 11);
            if (k == 1) push("pend_err_sticky", O_ERR, 32'h1);
            push_cycle("pend", k, (k <= 21) || (k >= 23 && k <= 43),
                       (k <= 21) ? 4'b1100 : ((k >= 23 && k <= 43) ? 4'b0111 : 4'hf),
                       (k >= 6) ? 16'h1514 : 16'h1511, 16'h1311,
                       (k >= 28) ? 8'h80 : 8'h00);
            tick();
        end
        wr_en = 1'b0; commit = 1'b0;
        rd("rd_ch3_sel", 2'd3, 2'd2, 4'd2);

        // Read and write of one address in the same cycle returns the old value.
        wr_en = 1'b1; wr_addr = {2'd3, 2'd2}; wr_data = 4'd1;
        rd_en = 1'b1; rd_addr = {2'd3, 2'd2};
        push("rd_wr_same", O_RD, {28'd0, rdx(4'd2)});
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        rd("rd_after_wr", 2'd3, 2'd2, 4'd1);

        // Write ch0 div_fb in its own APPLY cycle: old value applied, ch0 stays dirty.
        wr(2'd0, 2'd1, 4'd2);
        for (int k = 1; k <= 22; k++) begin
            commit  = (k == 1);
            wr_en   = (k == 6);
            wr_addr = {2'd0, 2'd0};
            wr_data = 4'd7;
            push_cycle("apw", k, k <= 21, (k <= 21) ? 4'b0110 : 4'hf, 16'h1514,
                       (k >= 6) ? 16'h1312 : 16'h1311,
                       (k >= 6) ? 8'h40 : 8'h80);
            tick();
        end
        wr_en = 1'b0; commit = 1'b0;
        rd("rd_ch0_fb_new", 2'd0, 2'd0, 4'd7);
        for (int k = 1; k <= 22; k++) begin
            commit = (k == 1);
            push_cycle("apw2", k, k <= 21, (k <= 21) ? 4'b1110 : 4'hf,
                       (k >= 6) ? 16'h1517 : 16'h1514, 16'h1312, 8'h40);
            tick();
        end
        commit = 1'b0;

        // Reset during QUIESCE with ch1 gated.
        wr(2'd1, 2'd0, 4'd9);
        commit = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            push_cycle("rq", k, 1'b1, 4'b1101, 16'h1517, 16'h1312, 8'h40);
            push($sformatf("rq_k%0d_err", k), O_ERR, 32'h1);
            tick();
            commit = 1'b0;
        end
        rst = 1'b1;
        push_cycle("rq_rst", 3, 1'b0, 4'hf, 16'h1111, 16'h1111, 8'h00);
        push("rq_rst_err", O_ERR, 32'h0);
        tick();
        rst = 1'b0;
        rd("rd_rst_ch1_fb", 2'd1, 2'd0, 4'd1);
        commit = 1'b1;
        push("post_rst_commit_busy0", O_BUSY, 32'h0);
        tick();
        commit = 1'b0;
        push("post_rst_commit_busy1", O_BUSY, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
